// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, flag bit positions and writeback buffer states
package gpu_pkg;
  localparam int RW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;
endpackage

// File: rtl/gpu_flag_unit.sv
// gpu_flag_unit: Z/C/N flag registers with direct-write priority over ALU updates
module gpu_flag_unit
  import gpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_zn,
  input  logic       upd_c,
  input  logic       z_in,
  input  logic       c_in,
  input  logic       n_in,
  input  logic       flagwr,
  input  logic [2:0] flagwr_data,
  output logic [2:0] flags
);
  logic [2:0] flags_q, flags_d;
  always_comb begin
    flags_d         = flags_q;
    flags_d[FLAG_Z] = upd_zn ? z_in : flags_q[FLAG_Z];
    flags_d[FLAG_N] = upd_zn ? n_in : flags_q[FLAG_N];
    flags_d[FLAG_C] = upd_c ? c_in : flags_q[FLAG_C];
    flags_d         = flagwr ? flagwr_data : flags_d;
  end
  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end
  assign flags = flags_q;
endmodule

// File: rtl/gpu_alu_wb.sv
// gpu_alu_wb: ALU flag update and register-file write-port arbitration with a one-entry collision buffer
module gpu_alu_wb
  import gpu_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [RW-1:0] aluq,
  input  logic          alu_co,
  input  logic [AW-1:0] alu_dst,
  input  logic          alu_wr_en,
  input  logic          flag_zn_en,
  input  logic          flag_c_en,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [RW-1:0] load_data,
  input  logic          flagwr,
  input  logic [2:0]    flagwr_data,
  output logic          zero_flag,
  output logic          carry_flag,
  output logic          nega_flag,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [RW-1:0] rf_data,
  output logic          pend_valid,
  output logic [AW-1:0] pend_addr
);
  buf_state_e    state_q, state_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d, rf_addr_q, rf_addr_d;
  logic [RW-1:0] buf_data_q, buf_data_d, rf_data_q, rf_data_d;
  logic          rf_we_q, rf_we_d;
  logic          acc, alu_wr, full, fill;
  logic [2:0]    flags;
  always_comb begin
    full       = state_q == BUF_FULL;
    acc        = alu_valid & ~full;
    alu_wr     = acc & alu_wr_en;
    fill       = alu_wr & load_we;
    state_d    = (fill | (full & load_we)) ? BUF_FULL : BUF_EMPTY;
    buf_addr_d = fill ? alu_dst : buf_addr_q;
    buf_data_d = fill ? aluq : buf_data_q;
    rf_we_d    = load_we | full | alu_wr;
    rf_addr_d  = load_we ? load_addr : full ? buf_addr_q : alu_wr ? alu_dst : rf_addr_q;
    rf_data_d  = load_we ? load_data : full ? buf_data_q : alu_wr ? aluq : rf_data_q;
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end
  gpu_flag_unit u_flags (
    .clk         (sys_clk),
    .rst         (reset),
    .upd_zn      (acc & flag_zn_en),
    .upd_c       (acc & flag_c_en),
    .z_in        (aluq == '0),
    .c_in        (alu_co),
    .n_in        (aluq[RW-1]),
    .flagwr      (flagwr),
    .flagwr_data (flagwr_data),
    .flags       (flags)
  );
  assign alu_ready  = ~full;
  assign pend_valid = full;
  assign pend_addr  = buf_addr_q;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign zero_flag  = flags[FLAG_Z];
  assign carry_flag = flags[FLAG_C];
  assign nega_flag  = flags[FLAG_N];
endmodule

// File: tb/tb_gpu_alu_wb.sv
// tb_gpu_alu_wb: directed vector table plus randomized run against a queue-based writeback model
module tb_gpu_alu_wb;
  logic        sys_clk = 0;
  logic        reset, alu_valid, alu_ready, alu_co, alu_wr_en, flag_zn_en, flag_c_en;
  logic [31:0] aluq, load_data, rf_data;
  logic [4:0]  alu_dst, load_addr, rf_addr, pend_addr;
  logic        load_we, flagwr, zero_flag, carry_flag, nega_flag, rf_we, pend_valid;
  logic [2:0]  flagwr_data;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rst; logic valid; logic [31:0] aluq; logic co; logic [4:0] dst; logic wr; logic zn; logic cen;
    logic lwe; logic [4:0] laddr; logic [31:0] ldata; logic fw; logic [2:0] fdata;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_data; logic [2:0] e_flags; logic e_ready; logic e_pend; logic [4:0] e_paddr;
  } vec_t;
  typedef struct {logic [4:0] addr; logic [31:0] data;} wr_t;
  vec_t vecs[16];
  wr_t  mq[$];
  always #5 sys_clk = ~sys_clk;
  gpu_alu_wb dut (
    .sys_clk(sys_clk), .reset(reset), .alu_valid(alu_valid), .alu_ready(alu_ready), .aluq(aluq),
    .alu_co(alu_co), .alu_dst(alu_dst), .alu_wr_en(alu_wr_en), .flag_zn_en(flag_zn_en),
    .flag_c_en(flag_c_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .flagwr(flagwr), .flagwr_data(flagwr_data), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .nega_flag(nega_flag), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pend_valid(pend_valid), .pend_addr(pend_addr)
  );
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    reset = v.rst; alu_valid = v.valid; aluq = v.aluq; alu_co = v.co; alu_dst = v.dst;
    alu_wr_en = v.wr; flag_zn_en = v.zn; flag_c_en = v.cen; load_we = v.lwe;
    load_addr = v.laddr; load_data = v.ldata; flagwr = v.fw; flagwr_data = v.fdata;
  endtask
  initial begin
    vec_t v;
    logic [2:0] mflags, mf_before;
    logic [4:0] m_addr;
    logic [31:0] m_data;
    logic m_we, acc;
    vecs[0]  = '{1,1,0,1,5,1,1,1,1,3,32'h5,1,3'b111, 0,0,0,3'b000,1,0,0};
    vecs[1]  = '{0,1,0,1,1,1,1,1,0,0,0,0,0, 1,1,0,3'b011,1,0,0};
    vecs[2]  = '{0,1,32'h80000001,0,7,1,1,0,0,0,0,0,0, 1,7,32'h80000001,3'b110,1,0,0};
    vecs[3]  = '{0,1,32'h1234,0,3,1,1,1,1,3,32'hAAAA,0,0, 1,3,32'hAAAA,3'b000,0,1,3};
    vecs[4]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 1,3,32'h1234,3'b000,1,0,0};
    vecs[5]  = '{0,1,32'h55,0,9,1,0,0,1,10,32'h111,0,0, 1,10,32'h111,3'b000,0,1,9};
    vecs[6]  = '{0,1,0,1,0,1,1,1,1,11,32'h222,0,0, 1,11,32'h222,3'b000,0,1,9};
    vecs[7]  = '{0,0,0,0,0,0,0,0,1,12,32'h333,0,0, 1,12,32'h333,3'b000,0,1,9};
    vecs[8]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 1,9,32'h55,3'b000,1,0,0};
    vecs[9]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0};
    vecs[10] = '{0,1,0,0,4,1,1,1,0,0,0,1,3'b010, 1,4,0,3'b010,1,0,0};
    vecs[11] = '{0,1,0,0,8,0,1,1,1,5,32'h77,0,0, 1,5,32'h77,3'b001,1,0,0};
    vecs[12] = '{0,1,32'hDEAD,0,6,1,0,0,1,2,32'h99,0,0, 1,2,32'h99,3'b001,0,1,6};
    vecs[13] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0};
    vecs[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0};
    vecs[15] = '{0,0,0,0,0,0,0,0,0,0,0,1,3'b101, 0,0,0,3'b101,1,0,0};
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(posedge sys_clk); #1;
      chk("rf_we", i, 32'(rf_we), 32'(vecs[i].e_we));
      chk("flags_nc_z", i, 32'({nega_flag, carry_flag, zero_flag}), 32'(vecs[i].e_flags));
      chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ready));
      chk("pend_valid", i, 32'(pend_valid), 32'(vecs[i].e_pend));
      if (vecs[i].e_we || vecs[i].rst) begin
        chk("rf_addr", i, 32'(rf_addr), 32'(vecs[i].e_addr));
        chk("rf_data", i, rf_data, vecs[i].e_data);
      end
      if (vecs[i].e_pend || vecs[i].rst) chk("pend_addr", i, 32'(pend_addr), 32'(vecs[i].e_paddr));
    end
    mflags = 0; m_addr = 0; m_data = 0; m_we = 0;
    for (int c = 0; c < 500; c++) begin
      v = vecs[9];
      v.rst   = (c == 0) || ($urandom_range(0, 60) == 0);
      v.valid = $urandom_range(0, 9) < 6;
      v.aluq  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      v.co    = 1'($urandom); v.dst = 5'($urandom); v.wr = $urandom_range(0, 4) != 0;
      v.zn    = 1'($urandom); v.cen = 1'($urandom);
      v.lwe   = $urandom_range(0, 9) < 4; v.laddr = 5'($urandom); v.ldata = $urandom;
      v.fw    = $urandom_range(0, 7) == 0; v.fdata = 3'($urandom);
      drive(v);
      if (v.rst) begin
        mflags = 0; mq.delete(); m_addr = 0; m_data = 0; m_we = 0;
      end else begin
        acc = v.valid && mq.size() == 0;
        mf_before = mflags;
        if (acc && v.zn) begin mflags[0] = v.aluq == 0; mflags[2] = v.aluq[31]; end
        if (acc && v.cen) mflags[1] = v.co;
        if (v.fw) mflags = v.fdata;
        m_we = 1;
        if (v.lwe) begin
          m_addr = v.laddr; m_data = v.ldata;
          if (acc && v.wr) mq.push_back('{v.dst, v.aluq});
        end else if (mq.size() != 0) begin
          m_addr = mq[0].addr; m_data = mq[0].data; mq.pop_front();
        end else if (acc && v.wr) begin
          m_addr = v.dst; m_data = v.aluq;
        end else m_we = 0;
        if (mf_before === 3'bxxx) mflags = 0;
      end
      @(posedge sys_clk); #1;
      chk("rnd_rf_we", c, 32'(rf_we), 32'(m_we));
      chk("rnd_rf_addr", c, 32'(rf_addr), 32'(m_addr));
      chk("rnd_rf_data", c, rf_data, m_data);
      chk("rnd_flags", c, 32'({nega_flag, carry_flag, zero_flag}), 32'(mflags));
      chk("rnd_alu_ready", c, 32'(alu_ready), 32'(mq.size() == 0));
      chk("rnd_pend_valid", c, 32'(pend_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("rnd_pend_addr", c, 32'(pend_addr), 32'(mq[0].addr));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpu_alu_wb.md
Name: gpu_alu_wb

Overview:
- Sits directly downstream of the 32-bit GPU/DSP ALU and consumes its result (aluq) and carry-out (alu_co).
- Computes and holds the Z/C/N flags. carry_flag feeds back into the ALU carry input.
- Arbitrates the single register-file write port between ALU results and memory-load writebacks.
- A one-entry holding buffer absorbs collisions. The execute stage is back-pressured through alu_ready.

Parameters:
- RW, 32, data width (ALU result / register width)
- AW, 5, register-file address width (32 registers per bank)

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  block can accept ALU result
- aluq  in  [0:RW-1]  ALU result, bit 0 = LSB
- alu_co  in  1  ALU carry/borrow out
- alu_dst  in  [0:AW-1]  destination register
- alu_wr_en  in  1  result is written back (0 for CMP/CMPQ)
- flag_zn_en  in  1  update Z,N from this result
- flag_c_en  in  1  update C from this result
- load_we  in  1  memory-load writeback request (highest priority)
- load_addr  in  [0:AW-1]  load destination register
- load_data  in  [0:RW-1]  load data
- flagwr  in  1  direct flags-register write
- flagwr_data  in  [0:2]  {Z,C,N} value for direct write
- zero_flag  out  1  Z flag
- carry_flag  out  1  C flag (to ALU carry_flag)
- nega_flag  out  1  N flag
- rf_we  out  1  register-file write strobe (registered)
- rf_addr  out  [0:AW-1]  register-file write address
- rf_data  out  [0:RW-1]  register-file write data
- pend_valid  out  1  ALU result held in buffer, not yet written
- pend_addr  out  [0:AW-1]  destination register of held result

Behaviour:
Reset:
- rf_we=0, rf_addr=0, rf_data=0.
- All flags 0.
- Buffer empty: pend_valid=0, pend_addr=0, alu_ready=1.
- Reset mid-operation discards any held result; no write is issued for it.

Handshake:
- Accept = alu_valid & alu_ready.
- alu_ready = ~buf_full, driven directly from a register with no combinational path from inputs.
- aluq, alu_co, alu_dst and the enables are sampled only on accept.

Flags (update on accept, independent of writeback, so the next ALU op sees new C after 1 cycle):
- Z = (aluq == 0), when flag_zn_en.
- N = aluq[31], when flag_zn_en.
- C = alu_co, when flag_c_en.
- A flag whose enable is 0 holds its value.
- flagwr in the same cycle as accept: flagwr wins for all three flags and the ALU flag update is discarded.
- flagwr alone: {Z,C,N} <= flagwr_data.

Write-port arbitration, evaluated each cycle, outputs registered (1-cycle latency to rf_*):
1. load_we=1: write load_addr/load_data. If an accept with alu_wr_en=1 occurs in the same cycle, that result goes to the buffer.
2. Else, buffer full: write the buffered result and empty the buffer.
3. Else, accept with alu_wr_en=1: write aluq to alu_dst directly; the buffer stays empty.
4. Else: rf_we=0. rf_addr/rf_data hold their previous values.

Buffer FSM:
- EMPTY -> FULL on (accept & alu_wr_en & load_we).
- FULL -> EMPTY on ~load_we.
- FULL stays FULL while load_we=1; the buffered result is never dropped or overwritten.
- No accept is possible in FULL.

Ordering and pending outputs:
- An accept with alu_wr_en=0 never occupies the buffer or the write port, but still updates flags.
- A load and a buffered ALU result to the same register: the load is written first and the ALU result second, so the ALU value is final.
- pend_valid=buf_full and pend_addr=buffered dst, for upstream scoreboarding.

Decomposition:
- Shared package gpu_pkg holds RW/AW defaults and the flag bit positions: FLAG_Z=0, FLAG_C=1, FLAG_N=2, matching flagwr_data and the G_FLAGS layout.
- One sub-module, gpu_flag_unit: flag registers plus the flagwr/ALU priority. Arbitration and the buffer stay in the top.

Test Plan:
- Reset, then accept aluq=0, alu_co=1, both flag enables -> next cycle Z=1, C=1, N=0; rf_we=1 at the following edge with rf_data=0.
- Accept aluq=0x80000001, dst=7, load_we=0 -> cycle+1: rf_we=1, rf_addr=7, rf_data=0x80000001, N=1, Z=0.
- Accept dst=3 aluq=0x1234 with load_we=1, load_addr=3, load_data=0xAAAA -> cycle+1 writes r3=0xAAAA and alu_ready=0, pend_valid=1, pend_addr=3; cycle+2 writes r3=0x1234 and alu_ready=1.
- Buffer full with load_we held 3 cycles -> three load writes, buffer retained and alu_ready=0 throughout; drains on the first cycle with load_we=0.
- flagwr=1, flagwr_data=3'b010 with simultaneous accept aluq=0 (Z candidate 1) -> Z=0, C=1, N=0; the ALU result is still written if alu_wr_en=1.
- CMP accept (alu_wr_en=0, aluq=0, alu_co=0) during load_we=1 -> no buffer fill, alu_ready stays 1, Z=1, C=0; reset asserted while buffer full -> pend_valid=0, no stale write follows.
